// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter and the downstream encoder stage.
// Holds the requester count, the FSM encoding and the one-hot to index helper.
package rr_grant_arbiter_pkg;

  localparam int N     = 8;
  localparam int PTR_W = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Returns the index of the set bit; callers only pass one-hot or zero vectors.
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N-1:0] v);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_grant_arbiter_if;
  import rr_grant_arbiter_pkg::*;

  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic         timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_valid,
    output timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority pick: first set request at or above ptr, wrapping.
module rr_pick
  import rr_grant_arbiter_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     sel,
  output logic             any
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_sel;

  // Rotating right puts requester ptr at bit 0, so a plain lowest-bit isolate is the pick.
  always_comb begin
    rot     = (req >> ptr) | (req << (N - int'(ptr)));
    rot_sel = rot & (~rot + N'(1));
    sel     = (rot_sel << ptr) | (rot_sel >> (N - int'(ptr)));
    any     = |req;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Non-preemptive round-robin arbiter with registered one-hot grant and hold timeout.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input logic               clk,
  input logic               rst_n,
  rr_grant_arbiter_if.slave bus
);

  localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;

  arb_state_e       state;
  logic [N-1:0]     grant_q;
  logic             grant_valid_q;
  logic             timeout_q;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W-1:0] pick_ptr;
  logic [PTR_W-1:0] owner_idx;
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_expired;
  logic             release_now;
  logic [N-1:0]     sel;
  logic             any;

  // While busy the pick already uses the post-release pointer so a new grant lands on the release edge.
  always_comb begin
    owner_idx    = onehot_to_idx(grant_q);
    next_ptr     = (owner_idx == PTR_W'(N - 1)) ? '0 : owner_idx + PTR_W'(1);
    hold_expired = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST);
    release_now  = (state == BUSY) && (bus.done || hold_expired);
    pick_ptr     = (state == BUSY) ? next_ptr : ptr;
  end

  rr_pick u_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .sel (sel),
    .any (any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      ptr           <= '0;
      hold_cnt      <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            grant_q       <= sel;
            grant_valid_q <= 1'b1;
            hold_cnt      <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            // A coincident done wins, so only a pure expiry reports a timeout.
            timeout_q <= !bus.done;
            ptr       <= next_ptr;
            hold_cnt  <= '0;
            if (any) begin
              grant_q <= sel;
            end else begin
              grant_q       <= '0;
              grant_valid_q <= 1'b0;
              state         <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter that sits directly upstream of the 8-to-3 encoder. It collects up to eight request lines and issues exactly one registered, one-hot grant at a time. The grant is held until the owner signals completion or a hold timeout expires. Its `grant` vector is the legal one-hot input the encoder stage converts to a 3-bit index.

## Interface
- `N`, 8: number of requesters; `grant` is N bits, one-hot or zero.
- `HOLD_MAX`, 15: maximum cycles a grant may be held before forced release; 0 disables the timeout.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  N  request lines, level-sensitive, bit i = requester i.
- `done`  in  1  owner releases the current grant; sampled only while `grant_valid`=1.
- `grant`  out  N  registered one-hot grant; all-zero when idle.
- `grant_valid`  out  1  high iff `grant` is nonzero.
- `timeout`  out  1  one-cycle pulse on the cycle a grant is force-released.

## Operation
- Reset (`rst_n`=0 at an edge): `grant`=0, `grant_valid`=0, `timeout`=0, pointer `ptr`=0, hold counter=0, state IDLE. Reset applied mid-grant clears everything at that same edge.
- Two states: IDLE and BUSY.
- Selection rule: choose the first set bit of `req` scanning from index `ptr` upward, wrapping from N-1 to 0.
- IDLE: if `req`≠0, register the selected one-hot grant, set `grant_valid`, clear the counter, go to BUSY. If `req`=0, stay in IDLE. `done` is ignored in IDLE.
- BUSY:
  - Non-preemptive. The grant is held even if the owner drops `req`, and other requests are ignored.
  - The counter increments every cycle.
- Release occurs on `done`=1, or when the counter reaches HOLD_MAX-1 with HOLD_MAX≠0.
- On release, `ptr` ← (granted index + 1) mod N.
  - The next selection uses the updated `ptr` and the current `req`, in the same edge (back-to-back grant, no idle gap).
  - The previous owner is lowest priority but is re-granted if it is the only requester.
  - If `req`=0 at release, `grant`←0 and state → IDLE.
- `done` and timeout on the same cycle are treated as `done`: `timeout` stays 0.
- `timeout`=1 for exactly the cycle after a forced release edge; it is registered and otherwise 0.
- Invariant: `grant` never has more than one bit set.

## Timing
- Request-to-grant latency: `req` sampled at edge k → `grant` valid after edge k (1 cycle) when IDLE.
- Release latency: `done` high at edge k → old grant removed and next grant (if any) present after edge k.
- Maximum hold: with no `done`, the grant lasts exactly HOLD_MAX cycles.
- Fairness: every continuously asserted requester is granted within N grants.
- All outputs are registered; there is no combinational path from `req` or `done` to outputs.

## Structure
- Shared package: `N` default and the state encoding (IDLE=0, BUSY=1).
  - The encoder stage imports the same package for `N`.
- One sub-module, `rr_pick`: combinational rotate-priority pick.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `sel` and `any`.
  - Implementation: rotate right by `ptr`, fixed priority on bit 0, rotate back.
- Top level holds the state register, `ptr`, the hold counter of width clog2(HOLD_MAX+1), and the output registers.

## Test plan
- Reset with `req`=8'hFF held → `grant`=0, `grant_valid`=0. First edge after release of reset → `grant`=8'h01.
- `req`=8'hFF constant, `done` pulsed every 2nd cycle → `grant` cycles 01,02,04,…,80,01 with no zero cycles between grants.
- `req`=8'b0010_0100 with `ptr`=3 (after a grant of index 2) → `grant`=8'h20. Then `done` → `grant`=8'h04, showing wrap-around.
- Grant to index 0, then `req` drops to 0, `done` never asserted, HOLD_MAX=15 → grant held 15 cycles. `timeout` pulses once, then `grant`=0 and state is IDLE.
- `done` and timeout coincide on the 15th cycle → release happens and `timeout` stays 0.
- `rst_n`=0 asserted while `grant`=8'h10 → `grant`=0 after that edge. After reset releases, with `req`=8'h10, the next grant is 8'h10 because `ptr` was reset to 0.
- Throughout all scenarios, assert `grant` is one-hot or zero and `grant_valid` == |`grant`. Feed `grant` into the encoder and check its index output.
